// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction-fetch
// unit and the load/store unit of the RISC16 core.
//
// Each requester holds req until it sees its one-cycle ack. Accesses are
// serialised and go through IDLE -> ACCESS (1+WAIT_STATES cycles) -> DONE.
// When both sides request at once, the side not granted last time wins.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   if_req_i, if_addr_i           fetch request / word address
//   if_ack_o                      fetch completion pulse
//   d_req_i, d_we_i, d_addr_i,    data request, 1 = store, address,
//   d_wdata_i                     store data
//   d_ack_o                       data completion pulse
//   rdata_o                       read data, non-zero only in a read ack cycle
//   mem_en_o, mem_we_o,           memory strobe, write enable,
//   mem_addr_o, mem_wdata_o       address, write data
//   mem_rdata_i                   synchronous memory read data
//   busy_o                        high while not idle
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    localparam logic [3:0] WaitLast = 4'(WAIT_STATES);
    localparam logic       OwnFetch = 1'b0;
    localparam logic       OwnData  = 1'b1;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e              state_q, state_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    // Store flag survives past ACCESS so the DONE cycle knows to gate rdata.
    logic                op_we_q, op_we_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_ack_q, if_ack_d;
    logic                d_ack_q, d_ack_d;
    logic                grant_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            owner_q     <= OwnFetch;
            last_q      <= OwnData;  // fetch wins the first tie
            op_we_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            op_we_q     <= op_we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    // Data wins only if fetch is absent or fetch had the previous grant.
    assign grant_data = d_req_i && (!if_req_i || (last_q == OwnFetch));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        op_we_d     = op_we_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                mem_en_d    = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
                if (if_req_i || d_req_i) begin
                    owner_d    = grant_data ? OwnData : OwnFetch;
                    last_d     = grant_data ? OwnData : OwnFetch;
                    op_we_d    = grant_data && d_we_i;
                    mem_en_d   = 1'b1;
                    mem_we_d   = grant_data && d_we_i;
                    mem_addr_d = grant_data ? d_addr_i : if_addr_i;
                    mem_wdata_d = (grant_data && d_we_i) ? d_wdata_i : '0;
                    wait_cnt_d = '0;
                    state_d    = StAccess;
                end
            end
            StAccess: begin
                if (wait_cnt_q == WaitLast) begin
                    mem_en_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    if_ack_d    = (owner_q == OwnFetch);
                    d_ack_d     = (owner_q == OwnData);
                    wait_cnt_d  = '0;
                    state_d     = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign if_ack_o    = if_ack_q;
    assign d_ack_o     = d_ack_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = (state_q != StIdle);
    assign rdata_o     = (if_ack_q || (d_ack_q && !op_we_q)) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances share the requester
// stimulus: instance 0 has no wait states, instance 1 has three, instance 2 has
// two. Each instance has its own small synchronous memory model preloaded with
// 16'hA000 + address (address 4 holds 16'h1234).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned Ws = (g == 0) ? 0 : ((g == 1) ? 3 : 2);

        logic        if_ack;
        logic        d_ack;
        logic [15:0] rdata;
        logic        mem_en;
        logic        mem_we;
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic [15:0] mem_rdata;
        logic        busy;
        logic [15:0] mem [0:255];

        mem_port_arbiter #(
            .ADDR_W     (16),
            .DATA_W     (16),
            .WAIT_STATES(Ws)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .if_req_i   (if_req),
            .if_addr_i  (if_addr),
            .if_ack_o   (if_ack),
            .d_req_i    (d_req),
            .d_we_i     (d_we),
            .d_addr_i   (d_addr),
            .d_wdata_i  (d_wdata),
            .d_ack_o    (d_ack),
            .rdata_o    (rdata),
            .mem_en_o   (mem_en),
            .mem_we_o   (mem_we),
            .mem_addr_o (mem_addr),
            .mem_wdata_o(mem_wdata),
            .mem_rdata_i(mem_rdata),
            .busy_o     (busy)
        );

        initial begin
            mem_rdata = 16'h0000;
            for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
            mem[4] = 16'h1234;
        end

        // Read old contents, then apply a write.
        always @(posedge clk) begin
            if (mem_en) begin
                mem_rdata <= mem[mem_addr[7:0]];
                if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        if_req  = 1'b1;
        d_req   = 1'b1;
        d_we    = 1'b0;
        if_addr = 16'h0004;
        d_addr  = 16'h0008;
        d_wdata = 16'h0000;

        // Reset held two cycles with both requests high.
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst_mem_en", g_inst[0].mem_en, 1'b0);
            chk("rst_mem_we", g_inst[0].mem_we, 1'b0);
            chk("rst_mem_addr", g_inst[0].mem_addr, 16'h0000);
            chk("rst_mem_wdata", g_inst[0].mem_wdata, 16'h0000);
            chk("rst_acks", {g_inst[0].if_ack, g_inst[0].d_ack}, 2'b00);
            chk("rst_rdata", g_inst[0].rdata, 16'h0000);
            chk("rst_busy", g_inst[0].busy, 1'b0);
        end
        rst = 1'b0;

        // First tie after reset goes to fetch.
        step();
        chk("tie0_mem_en", g_inst[0].mem_en, 1'b1);
        chk("tie0_mem_addr", g_inst[0].mem_addr, 16'h0004);
        chk("tie0_mem_we", g_inst[0].mem_we, 1'b0);
        step();
        chk("tie0_if_ack", g_inst[0].if_ack, 1'b1);
        chk("tie0_d_ack", g_inst[0].d_ack, 1'b0);
        chk("tie0_rdata", g_inst[0].rdata, 16'h1234);
        if_req = 1'b0;
        d_req  = 1'b0;
        step();
        chk("tie0_idle", {g_inst[0].busy, g_inst[0].if_ack, g_inst[0].d_ack}, 3'b000);

        // Single fetch.
        if_req  = 1'b1;
        if_addr = 16'h0004;
        step();
        chk("fetch_mem_en", g_inst[0].mem_en, 1'b1);
        chk("fetch_mem_addr", g_inst[0].mem_addr, 16'h0004);
        chk("fetch_mem_we", g_inst[0].mem_we, 1'b0);
        chk("fetch_mem_wdata", g_inst[0].mem_wdata, 16'h0000);
        chk("fetch_no_ack_early", g_inst[0].if_ack, 1'b0);
        step();
        chk("fetch_if_ack", g_inst[0].if_ack, 1'b1);
        chk("fetch_rdata", g_inst[0].rdata, 16'h1234);
        chk("fetch_d_ack", g_inst[0].d_ack, 1'b0);
        chk("fetch_mem_en_off", g_inst[0].mem_en, 1'b0);
        if_req = 1'b0;
        step();
        chk("fetch_ack_pulse", g_inst[0].if_ack, 1'b0);

        // Store 0xBEEF to 0x0010.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0010;
        d_wdata = 16'hBEEF;
        step();
        chk("store_mem_en", g_inst[0].mem_en, 1'b1);
        chk("store_mem_we", g_inst[0].mem_we, 1'b1);
        chk("store_mem_addr", g_inst[0].mem_addr, 16'h0010);
        chk("store_mem_wdata", g_inst[0].mem_wdata, 16'hBEEF);
        step();
        chk("store_d_ack", g_inst[0].d_ack, 1'b1);
        chk("store_rdata", g_inst[0].rdata, 16'h0000);
        chk("store_mem_we_off", g_inst[0].mem_we, 1'b0);
        chk("store_mem_content", g_inst[0].mem[16], 16'hBEEF);
        d_req = 1'b0;
        step();

        // Load the stored word back.
        d_req = 1'b1;
        d_we  = 1'b0;
        step();
        chk("load_mem_we", g_inst[0].mem_we, 1'b0);
        step();
        chk("load_d_ack", g_inst[0].d_ack, 1'b1);
        chk("load_rdata", g_inst[0].rdata, 16'hBEEF);
        d_req = 1'b0;
        step();

        // Contention: both held, last grant was data, so fetch goes first.
        if_req  = 1'b1;
        if_addr = 16'h0020;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 16'h0030;
        for (int n = 0; n < 6; n++) begin
            step();
            chk("cont_mem_addr", g_inst[0].mem_addr, (n % 2 == 0) ? 16'h0020 : 16'h0030);
            step();
            chk("cont_acks", {g_inst[0].if_ack, g_inst[0].d_ack},
                (n % 2 == 0) ? 2'b10 : 2'b01);
            chk("cont_rdata", g_inst[0].rdata, (n % 2 == 0) ? 16'hA020 : 16'hA030);
            step();
            chk("cont_ack_pulse", {g_inst[0].if_ack, g_inst[0].d_ack}, 2'b00);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        for (int k = 0; k < 10; k++) step();

        // Wait states = 3: single load on instance 1.
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0040;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("ws_mem_en", g_inst[1].mem_en, 1'b1);
            chk("ws_mem_addr", g_inst[1].mem_addr, 16'h0040);
            chk("ws_busy", g_inst[1].busy, 1'b1);
            chk("ws_no_ack", g_inst[1].d_ack, 1'b0);
        end
        step();
        chk("ws_d_ack", g_inst[1].d_ack, 1'b1);
        chk("ws_rdata", g_inst[1].rdata, 16'hA040);
        chk("ws_mem_en_off", g_inst[1].mem_en, 1'b0);
        chk("ws_busy_done", g_inst[1].busy, 1'b1);
        d_req = 1'b0;
        step();
        chk("ws_busy_end", g_inst[1].busy, 1'b0);
        for (int k = 0; k < 10; k++) step();

        // Abort on instance 2 (wait states = 2): reset in the second ACCESS cycle.
        if_req  = 1'b1;
        if_addr = 16'h0050;
        step();
        chk("abort_mem_en_c1", g_inst[2].mem_en, 1'b1);
        step();
        chk("abort_mem_en_c2", g_inst[2].mem_en, 1'b1);
        rst = 1'b1;
        step();
        chk("abort_mem_en_off", g_inst[2].mem_en, 1'b0);
        chk("abort_busy", g_inst[2].busy, 1'b0);
        chk("abort_no_ack", g_inst[2].if_ack, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("reissue_mem_en", g_inst[2].mem_en, 1'b1);
            chk("reissue_no_ack", g_inst[2].if_ack, 1'b0);
        end
        step();
        chk("reissue_if_ack", g_inst[2].if_ack, 1'b1);
        chk("reissue_rdata", g_inst[2].rdata, 16'hA050);
        if_req = 1'b0;
        step();
        chk("reissue_ack_pulse", g_inst[2].if_ack, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port program/data memory of the RISC16 core between the instruction-fetch unit and the load/store unit. Each requester uses a req/ack handshake. The arbiter serialises accesses, drives the memory port, and returns read data with a one-cycle ack pulse. Round-robin tie-breaking guarantees neither side starves; wait states are configurable for slower memories.

## Interface
- ADDR_W, 16, memory word-address width
- DATA_W, 16, memory word width
- WAIT_STATES, 0, extra cycles the memory port is held per access (0..15)

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load; stable while d_req
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle completion pulse for data
- rdata  out  DATA_W  read data, valid only in the ack cycle of a read; 0 otherwise
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  synchronous read data, valid the cycle after the last mem_en cycle
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE**
  - All mem_* outputs are 0.
  - If any req is high, select a winner and register owner, mem_addr, mem_we and mem_wdata. Set mem_en=1 and go to ACCESS.
  - If no req is high, stay in IDLE.
- **Arbitration**
  - A single requester wins.
  - If both request, the requester not granted last time wins.
  - `last` records the most recent winner. It updates on every grant.
- **Fetch grant:** mem_we=0 and mem_wdata=0.
- **ACCESS**
  - mem_en, mem_we, mem_addr and mem_wdata are held constant for 1+WAIT_STATES cycles, counted by a 4-bit wait counter.
  - On the final cycle, mem_* are cleared and the state goes to DONE.
- **DONE**
  - Assert ack for exactly one cycle to the owner.
  - rdata = mem_rdata for a read owner; rdata = 0 for a store.
  - Return to IDLE.
- **Requester rule:** drop req on the edge ending the ack cycle. A req still high in IDLE after ack is treated as a new request.
- **Reset (`rst`)**
  - Forces IDLE and clears the wait counter.
  - Sets `last` = data, so fetch wins the first tie.
  - All outputs are 0 the cycle after.
  - Reset mid-ACCESS aborts the transaction: no ack is issued, and a store may or may not have reached memory.
- Requests arriving during ACCESS/DONE are not sampled until IDLE.
- d_we, addr and wdata changes during ACCESS have no effect, because they are registered at grant.
- Outputs are registered, except rdata, which is combinational from mem_rdata gated by ack.

## Timing
- Reset value of every output: 0.
- Sequence with req high at edge E0 in IDLE:
  - mem_en is high in cycles E0+1 .. E0+1+WAIT_STATES.
  - ack is high in cycle E0+2+WAIT_STATES.
- Access latency from req sampled to ack: 2+WAIT_STATES cycles.
- Back-to-back cost: 3+WAIT_STATES cycles per access, including one IDLE cycle.
- With both requesters continuously requesting, grants alternate strictly.

## Test plan
- **Reset check:** assert rst for 2 cycles with both reqs high → all outputs 0 during and 1 cycle after reset. The first grant after release goes to fetch.
- **Single fetch:** if_addr=0x0004, mem model returns 0x1234, WAIT_STATES=0 → mem_en high for 1 cycle with mem_addr=0x0004, mem_we=0. if_ack and rdata=0x1234 appear 2 cycles after req is sampled; d_ack stays 0.
- **Store:** d_we=1, d_addr=0x0010, d_wdata=0xBEEF → mem_we=1, mem_wdata=0xBEEF for one cycle. d_ack follows with rdata=0; the memory model holds 0xBEEF at 0x0010.
- **Contention:** both reqs held for 6 grants → grant order fetch, data, fetch, data, fetch, data; each ack is exactly one cycle and acks are never simultaneous.
- **Wait states:** WAIT_STATES=3, single load → mem_en and mem_addr stable for 4 cycles; ack arrives 5 cycles after req is sampled; busy is high for 5 cycles.
- **Abort:** rst asserted during the second cycle of ACCESS (WAIT_STATES=2) → no ack; mem_en is 0 the next cycle. A re-issued request then completes normally.
